// File: rtl/jtframe_prog_pkg.sv
// Shared types and constants for the download-to-SDRAM programming path.
//   prog_st_t    : loader FSM state
//   fifo_entry_t : one buffered download byte (byte address + data)
//   MASK_*       : active-low SDRAM byte enables
package jtframe_prog_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStrobe,
    StProm,
    StGap
  } prog_st_t;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Small circular FIFO for download bytes.
//   clk_i, rst_ni : clock, synchronous active-low reset (flushes the FIFO)
//   push_i        : write wdata_i; ignored when full unless pop_i is also high
//   pop_i         : drop the head entry; ignored when empty
//   head_o        : entry at the read pointer (valid when !empty_o)
//   full_o/empty_o/count_o : occupancy
module jtframe_prog_fifo
  import jtframe_prog_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic               pop_i,
  input  fifo_entry_t        wdata_i,
  output fifo_entry_t        head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   count_o
);

  localparam int unsigned        Depth   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   FullCnt = (FIFO_AW + 1)'(Depth);

  fifo_entry_t          mem_q [Depth];
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic                 wr_en, rd_en;

  always_comb begin
    full_o  = (count_q == FullCnt);
    empty_o = (count_q == '0);
    count_o = count_q;
    head_o  = mem_q[rd_ptr_q];
    // When full, a simultaneous pop frees the slot being written.
    wr_en   = push_i & (~full_o | pop_i);
    rd_en   = pop_i & ~empty_o;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/jtframe_prog_loader.sv
// Converts the MiST byte download stream into SDRAM byte-masked word writes.
// Bytes are buffered in a FIFO; each SDRAM write holds prog_we for PROG_LEN
// cycles, PROM-range bytes get a single prom_we cycle, and GAP idle cycles
// separate writes. dwnld_done pulses once the download has fully drained.
//   clk_rom, rst_n            : clock, synchronous active-low reset
//   downloading, ioctl_*      : download port from the base
//   prog_addr/data/mask/we    : SDRAM programming port (mask active-low)
//   prom_we, prom_addr        : PROM write port
//   overflow                  : sticky byte-dropped flag
//   busy, dwnld_done          : drain status
module jtframe_prog_loader
  import jtframe_prog_pkg::*;
#(
  parameter int unsigned FIFO_AW    = 2,
  parameter int unsigned PROG_LEN   = 8,
  parameter int unsigned GAP        = 2,
  parameter logic [21:0] PROM_START = 22'h3F_0000,
  parameter int unsigned PROM_AW    = 10
) (
  input  logic               clk_rom,
  input  logic               rst_n,
  input  logic               downloading,
  input  logic [21:0]        ioctl_addr,
  input  logic [7:0]         ioctl_data,
  input  logic               ioctl_wr,
  output logic [21:0]        prog_addr,
  output logic [7:0]         prog_data,
  output logic [1:0]         prog_mask,
  output logic               prog_we,
  output logic               prom_we,
  output logic [PROM_AW-1:0] prom_addr,
  output logic               overflow,
  output logic               busy,
  output logic               dwnld_done
);

  localparam int unsigned     CntW      = 8;
  localparam logic [CntW-1:0] StrobeLd  = CntW'(PROG_LEN - 1);
  localparam logic [CntW-1:0] GapLd     = (GAP == 0) ? '0 : CntW'(GAP - 1);
  localparam prog_st_t        AfterWr   = (GAP == 0) ? StIdle : StGap;

  prog_st_t             st_q, st_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [21:0]          prog_addr_q, prog_addr_d;
  logic [7:0]           prog_data_q, prog_data_d;
  logic [1:0]           prog_mask_q, prog_mask_d;
  logic [PROM_AW-1:0]   prom_addr_q, prom_addr_d;
  logic                 prog_we_q, prog_we_d;
  logic                 prom_we_q, prom_we_d;
  logic                 overflow_q, overflow_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pending_q, pending_d;
  logic                 dl_q;

  fifo_entry_t          wentry, head;
  logic                 fifo_full, fifo_empty;
  logic [FIFO_AW:0]     fifo_count, count_nx;
  logic                 push, pop, drop, dl_rise;

  jtframe_prog_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk_i   (clk_rom),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wentry),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    wentry   = '{addr: ioctl_addr, data: ioctl_data};
    push     = ioctl_wr & downloading;
    pop      = (st_q == StIdle) & ~fifo_empty;
    drop     = push & fifo_full & ~pop;
    dl_rise  = downloading & ~dl_q;

    st_d        = st_q;
    cnt_d       = cnt_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_mask_d = prog_mask_q;
    prom_addr_d = prom_addr_q;

    unique case (st_q)
      StIdle: begin
        if (!fifo_empty) begin
          prog_data_d = head.data;
          if (head.addr < PROM_START) begin
            st_d        = StStrobe;
            prog_addr_d = {1'b0, head.addr[21:1]};
            prog_mask_d = head.addr[0] ? MASK_HI : MASK_LO;
            cnt_d       = StrobeLd;
          end else begin
            st_d        = StProm;
            prom_addr_d = PROM_AW'(head.addr - PROM_START);
          end
        end
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          st_d  = AfterWr;
          cnt_d = GapLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StProm: begin
        st_d  = AfterWr;
        cnt_d = GapLd;
      end
      StGap: begin
        if (cnt_q == '0) st_d = StIdle;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: st_d = StIdle;
    endcase

    // Next-cycle occupancy lets busy and dwnld_done line up on the same edge.
    count_nx = fifo_count;
    unique case ({push & ~drop, pop})
      2'b10:   count_nx = fifo_count + 1'b1;
      2'b01:   count_nx = fifo_count - 1'b1;
      default: count_nx = fifo_count;
    endcase

    prog_we_d  = (st_d == StStrobe);
    prom_we_d  = (st_d == StProm);
    busy_d     = (count_nx != '0) | (st_d != StIdle);
    done_d     = pending_q & ~downloading & (count_nx == '0) & (st_d == StIdle);
    overflow_d = (dl_rise ? 1'b0 : overflow_q) | drop;

    pending_d = pending_q;
    if (dl_rise)     pending_d = 1'b1;
    else if (done_d) pending_d = 1'b0;
  end

  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      st_q        <= StIdle;
      cnt_q       <= '0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= MASK_NONE;
      prom_addr_q <= '0;
      prog_we_q   <= 1'b0;
      prom_we_q   <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pending_q   <= 1'b0;
      dl_q        <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_mask_q <= prog_mask_d;
      prom_addr_q <= prom_addr_d;
      prog_we_q   <= prog_we_d;
      prom_we_q   <= prom_we_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pending_q   <= pending_d;
      dl_q        <= downloading;
    end
  end

  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign prog_mask  = prog_mask_q;
  assign prog_we    = prog_we_q;
  assign prom_we    = prom_we_q;
  assign prom_addr  = prom_addr_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;
  assign dwnld_done = done_q;

endmodule

// File: tb/tb_jtframe_prog_loader.sv
// Self-checking bench for jtframe_prog_loader: table of single bytes, then
// burst/overflow, done timing and reset-during-strobe sequences. Expected
// writes go into a scoreboard queue and are checked when a strobe rises.
module tb_jtframe_prog_loader;

  localparam int PROG_LEN = 8;
  localparam int GAP      = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [21:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we, prom_we, overflow, busy, dwnld_done;
  logic [9:0]  prom_addr;

  jtframe_prog_loader dut (
    .clk_rom     (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .prom_we     (prom_we),
    .prom_addr   (prom_addr),
    .overflow    (overflow),
    .busy        (busy),
    .dwnld_done  (dwnld_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_prom;
    logic [21:0] paddr;
    logic [1:0]  mask;
    logic [7:0]  data;
    logic [9:0]  prom_addr;
    bit          chk_lat;
    int          exp_cyc;
  } exp_t;

  typedef struct {
    logic [21:0] addr;
    logic [7:0]  data;
    bit          is_prom;
    logic [21:0] paddr;
    logic [1:0]  mask;
    logic [9:0]  prom_addr;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [21:0] a, input logic [7:0] d, input bit lat);
    exp_t e;
    logic [21:0] off;
    off         = a - 22'h3F0000;
    e.is_prom   = (a >= 22'h3F0000);
    e.paddr     = {1'b0, a[21:1]};
    e.mask      = a[0] ? 2'b01 : 2'b10;
    e.data      = d;
    e.prom_addr = off[9:0];
    e.chk_lat   = lat;
    e.exp_cyc   = 0;
    return e;
  endfunction

  // ---------------- monitor ----------------
  bit          prev_pwe = 0, prev_prom = 0, prev_busy = 0;
  bit          skip_len = 0;
  int          pwe_len = 0, prom_len = 0;
  int          n_writes = 0, done_cnt = 0, done_cyc = -1, busy_fall_cyc = -1;
  logic [21:0] last_paddr = '0;
  logic [1:0]  last_mask = 2'b11;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (prog_we && !prev_pwe) begin
      n_writes++;
      pwe_len = 0;
      if (sb.size() == 0) chk("unexpected_prog_we", 32'(prog_we), 0);
      else begin
        mon_e = sb.pop_front();
        chk("sdram_vs_prom_kind", 32'(prom_we), 32'(mon_e.is_prom));
        chk("prog_addr", 32'(prog_addr), 32'(mon_e.paddr));
        chk("prog_mask", 32'(prog_mask), 32'(mon_e.mask));
        chk("prog_data", 32'(prog_data), 32'(mon_e.data));
        if (mon_e.chk_lat) chk("prog_we_latency", cyc, mon_e.exp_cyc);
        last_paddr = mon_e.paddr;
        last_mask  = mon_e.mask;
      end
    end
    if (prog_we) pwe_len++;
    if (!prog_we && prev_pwe && !skip_len) chk("prog_we_len", pwe_len, PROG_LEN);

    if (prom_we && !prev_prom) begin
      n_writes++;
      prom_len = 0;
      if (sb.size() == 0) chk("unexpected_prom_we", 32'(prom_we), 0);
      else begin
        mon_e = sb.pop_front();
        chk("prom_kind", 32'(mon_e.is_prom), 1);
        chk("prom_addr", 32'(prom_addr), 32'(mon_e.prom_addr));
        chk("prom_data", 32'(prog_data), 32'(mon_e.data));
        chk("prog_we_during_prom", 32'(prog_we), 0);
        chk("prog_addr_hold", 32'(prog_addr), 32'(last_paddr));
        chk("prog_mask_hold", 32'(prog_mask), 32'(last_mask));
        if (mon_e.chk_lat) chk("prom_we_latency", cyc, mon_e.exp_cyc);
      end
    end
    if (prom_we) prom_len++;
    if (!prom_we && prev_prom && !skip_len) chk("prom_we_len", prom_len, 1);

    if (dwnld_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!busy && prev_busy) busy_fall_cyc = cyc;
    prev_pwe  = prog_we;
    prev_prom = prom_we;
    prev_busy = busy;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_one(input logic [21:0] a, input logic [7:0] d, input bit has_exp,
                           input exp_t e);
    exp_t t;
    @(negedge clk);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    if (has_exp) begin
      t = e;
      // Strobe is first visible two edges after the one sampling ioctl_wr.
      if (t.chk_lat) t.exp_cyc = cyc + 2;
      sb.push_back(t);
    end
  endtask

  task automatic end_drive();
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int max_cyc);
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk({nm, "_drain_timeout"}, 32'(ok), 1);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_prog_we"}, 32'(prog_we), 0);
    chk({nm, "_prom_we"}, 32'(prom_we), 0);
    chk({nm, "_prog_mask"}, 32'(prog_mask), 32'h3);
    chk({nm, "_prog_addr"}, 32'(prog_addr), 0);
    chk({nm, "_prog_data"}, 32'(prog_data), 0);
    chk({nm, "_prom_addr"}, 32'(prom_addr), 0);
    chk({nm, "_overflow"}, 32'(overflow), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(dwnld_done), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  vec_t vecs[8];
  exp_t ev;
  int   snap_done, snap_wr, c0;
  bit   seen;

  initial begin
    vecs[0] = '{22'h000010, 8'hA5, 1'b0, 22'h000008, 2'b10, 10'h000};
    vecs[1] = '{22'h000011, 8'h3C, 1'b0, 22'h000008, 2'b01, 10'h000};
    vecs[2] = '{22'h3F0005, 8'h77, 1'b1, 22'h000000, 2'b00, 10'h005};
    vecs[3] = '{22'h002345, 8'h5A, 1'b0, 22'h0011A2, 2'b01, 10'h000};
    vecs[4] = '{22'h3EFFFF, 8'h11, 1'b0, 22'h1F7FFF, 2'b01, 10'h000};
    vecs[5] = '{22'h3F0000, 8'hC3, 1'b1, 22'h000000, 2'b00, 10'h000};
    vecs[6] = '{22'h3FFFFF, 8'hEE, 1'b1, 22'h000000, 2'b00, 10'h3FF};
    vecs[7] = '{22'h1FFFFE, 8'h96, 1'b0, 22'h0FFFFF, 2'b10, 10'h000};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Strobe with downloading low is ignored.
    ev = model(22'h000020, 8'h12, 1'b0);
    drive_one(22'h000020, 8'h12, 1'b0, ev);
    end_drive();
    repeat (4) @(negedge clk);
    chk("gated_busy", 32'(busy), 0);
    chk("gated_writes", n_writes, 0);

    @(negedge clk);
    downloading = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ev = '{vecs[i].is_prom, vecs[i].paddr, vecs[i].mask, vecs[i].data,
             vecs[i].prom_addr, 1'b1, 0};
      drive_one(vecs[i].addr, vecs[i].data, 1'b1, ev);
      end_drive();
      wait_idle($sformatf("vec%0d", i), 40);
    end
    chk("vec_write_count", n_writes, 8);

    // Burst of six back-to-back bytes into a 4-deep FIFO.
    chk("ovf_before_burst", 32'(overflow), 0);
    for (int i = 0; i < 6; i++) begin
      ev = model(22'h000100 + 22'(i), 8'h40 + 8'(i), i == 0);
      drive_one(22'h000100 + 22'(i), 8'h40 + 8'(i), i < 5, ev);
    end
    end_drive();
    chk("ovf_after_burst", 32'(overflow), 1);
    wait_idle("burst", 120);
    chk("burst_write_count", n_writes, 13);
    chk("ovf_sticky", 32'(overflow), 1);
    @(negedge clk);
    downloading = 1'b0;
    repeat (3) @(negedge clk);
    downloading = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovf_cleared_on_rise", 32'(overflow), 0);

    // Done pulse after three queued bytes drain.
    snap_done = done_cnt;
    for (int i = 0; i < 3; i++) begin
      ev = model(22'h000200 + 22'(i), 8'h80 + 8'(i), 1'b0);
      drive_one(22'h000200 + 22'(i), 8'h80 + 8'(i), 1'b1, ev);
      if (i == 0) c0 = cyc;
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
    downloading = 1'b0;
    chk("done_not_early", done_cnt - snap_done, 0);
    wait_idle("done", 80);
    repeat (3) @(negedge clk);
    chk("done_pulse_count", done_cnt - snap_done, 1);
    chk("done_cycle", done_cyc, c0 + 1 + 3 * (PROG_LEN + GAP + 1));
    chk("done_with_busy_fall", done_cyc, busy_fall_cyc);

    // Reset during STROBE with a second byte still queued.
    @(negedge clk);
    downloading = 1'b1;
    ev = model(22'h000300, 8'h5C, 1'b1);
    drive_one(22'h000300, 8'h5C, 1'b1, ev);
    drive_one(22'h000302, 8'h5D, 1'b0, ev);
    end_drive();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (prog_we) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_test_strobe_seen", 32'(seen), 1);
    skip_len = 1;
    @(negedge clk);
    rst_n = 1'b0;
    downloading = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_reset");
    rst_n = 1'b1;
    sb.delete();
    snap_done = done_cnt;
    snap_wr   = n_writes;
    repeat (30) @(negedge clk);
    chk("no_done_after_reset", done_cnt - snap_done, 0);
    chk("fifo_flushed", n_writes - snap_wr, 0);
    chk("idle_after_reset", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
